// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the CPU control unit and the
// iterative multiply/divide unit.
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start_mult, start_div, a, b,
      input  hi_out, lo_out, busy, done, div_zero
   );

   modport slave (
      input  start_mult, start_div, a, b,
      output hi_out, lo_out, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: magnitudes are processed one bit per
// cycle (shift-add / restoring division), then signs are fixed up in FINISH.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   mult_div_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
   logic               sign_a;
   logic               sign_b;
   logic               op_div;
   logic               dz;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;
   logic               dz_q;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_w2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      prod_fix  = neg_w2(acc, sign_a ^ sign_b);
      quo_fix   = neg_w(acc[WIDTH-1:0], sign_a ^ sign_b);
      rem_fix   = neg_w(acc[2*WIDTH-1:WIDTH], sign_a);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         op_div <= 1'b0;
         dz     <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_mult || bus.start_div) begin
                  sign_a <= bus.a[WIDTH-1];
                  sign_b <= bus.b[WIDTH-1];
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  op_div <= !bus.start_mult;
                  dz     <= !bus.start_mult && (bus.b == '0);
                  if (bus.start_mult) begin
                     acc   <= {{WIDTH{1'b0}}, mag(bus.b)};
                     opnd  <= mag(bus.a);
                     state <= MULT;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, mag(bus.a)};
                     opnd  <= mag(bus.b);
                     state <= (bus.b == '0) ? FINISH : DIV;
                  end
               end
            end
            // iteration stage: one multiplier bit per cycle
            MULT: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
            end
            // iteration stage: one quotient bit per cycle, restore on negative trial
            DIV: begin
               if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
            end
            // sign fix-up and result write; divide-by-zero leaves results untouched
            FINISH: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= IDLE;
               if (dz) begin
                  dz_q <= 1'b1;
               end else if (op_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit with a result scoreboard.
module tb_mult_div_unit;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   t0       = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_div_if #(.WIDTH(W)) bus ();
   mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz, input int lat);
      exp_t e;
      e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
      sb.push_back(e);
   endtask

   // Operands are scrambled after the start cycle so the unit must have latched them.
   task automatic launch(input logic sm, input logic sd, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      bus.start_mult = sm; bus.start_div = sd; bus.a = av; bus.b = bv;
      @(negedge clk);
      bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a = $urandom; bus.b = $urandom;
      t0 = cyc;
   endtask

   task automatic wait_done(input string tag);
      int   guard = 0;
      logic busy_ok = 1'b1;
      exp_t e;
      logic [W-1:0] hi_now, lo_now;
      while (bus.done !== 1'b1 && guard < 200) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         chk({tag, "_timeout"}, 64'(bus.done), 64'd1);
         return;
      end
      chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
      if (sb.size() == 0) begin
         chk({tag, "_unexpected_done"}, 64'(bus.done), 64'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(cyc - t0), 64'(e.lat));
      chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
      chk({tag, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
      chk({tag, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
      hi_now = bus.hi_out;
      lo_now = bus.lo_out;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_dz_pulse"}, 64'(bus.div_zero), 64'd0);
      chk({tag, "_hold"}, {bus.hi_out, bus.lo_out}, {hi_now, lo_now});
   endtask

   task automatic run(input string tag, input logic sm, input logic sd, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic [W-1:0] hi, input logic [W-1:0] lo,
                      input logic dz, input int lat);
      push(hi, lo, dz, lat);
      launch(sm, sd, av, bv);
      chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
      wait_done(tag);
   endtask

   task automatic no_done_for(input string tag, input int n);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      longint       sa, sbv, q, r;
      logic [63:0]  p;
      logic         do_div;

      bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a = '0; bus.b = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_dz", 64'(bus.div_zero), 64'd0);
      chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
      reset = 1'b0;

      run("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, W + 1);
      run("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, W + 1);
      run("div_7_m2", 0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, W + 1);
      run("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, W + 1);
      run("div_by_zero", 0, 1, 32'd5, 32'd0, 32'h40000000, 32'h0, 1, 1);
      run("div_overflow", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, W + 1);

      // div request while busy must be dropped
      push(32'd0, 32'd12, 0, W + 1);
      launch(1, 0, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      bus.start_div = 1'b1; bus.a = 32'd100; bus.b = 32'd5;
      @(negedge clk);
      bus.start_div = 1'b0;
      wait_done("busy_ignore");
      no_done_for("busy_ignore_single_done", 50);

      run("both_starts", 1, 1, 32'd6, 32'd3, 32'd0, 32'd18, 0, W + 1);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? W'($urandom_range(1, 40)) : W'($urandom);
         if (rb == '0) rb = 32'd1;
         if (i % 2 == 1) ra = -ra;
         do_div = (i % 2 == 0);
         sa  = longint'($signed(ra));
         sbv = longint'($signed(rb));
         if (do_div) begin
            q = sa / sbv;
            r = sa % sbv;
            run("rand_div", 0, 1, ra, rb, W'(r), W'(q), 0, W + 1);
         end else begin
            p = 64'(sa * sbv);
            run("rand_mul", 1, 0, ra, rb, p[63:32], p[31:0], 0, W + 1);
         end
      end

      // reset in the middle of a division discards it
      launch(0, 1, 32'hFFFFFF9C, 32'd7);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
      no_done_for("mid_rst_no_done", 60);

      run("after_rst_mul", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 0, W + 1);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle CPU datapath.
- Operands come from the A/B register outputs. The control unit launches an operation with a one-cycle start pulse and waits for done.
- The control unit then asserts hi_w/lo_w to copy hi_out/lo_out into the architectural HI/LO registers.
- Implements MIPS mult and div semantics, and flags divide-by-zero so the control unit can take the exception path (epc_w).

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH; iteration count equals WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  reset, synchronous, active-high
start_mult  input  1  one-cycle request: signed a*b
start_div  input  1  one-cycle request: signed a/b
a  input  WIDTH  operand A (multiplicand / dividend), sampled on accepted start
b  input  WIDTH  operand B (multiplier / divisor), sampled on accepted start
hi_out  output  WIDTH  mult: product[2*WIDTH-1:WIDTH]; div: remainder
lo_out  output  WIDTH  mult: product[WIDTH-1:0]; div: quotient
busy  output  1  high while an operation is in progress (not in IDLE)
done  output  1  one-cycle pulse: hi_out/lo_out valid and updated
div_zero  output  1  one-cycle pulse coincident with done when divisor was 0

Behaviour:
- Reset: on any edge with reset=1, state <- IDLE; hi_out, lo_out, internal accumulators <- 0; busy, done, div_zero <- 0. Reset overrides everything, including an operation in progress, which is discarded.
- States:
  - IDLE: waiting for a start.
  - MULT: WIDTH iterations.
  - DIV: WIDTH iterations.
  - FINISH: one cycle, sign fix-up and output write.
- Start acceptance:
  - A start is accepted only in IDLE. start_mult/start_div seen in any other state are ignored, with no queuing.
  - If both are high in IDLE, mult takes priority and start_div is dropped.
- Accepted start at edge N: latch a and b, store operand signs, and convert both to magnitudes (two's-complement abs; abs(-2^(WIDTH-1)) = 2^(WIDTH-1) as an unsigned WIDTH-bit value). busy=1 from edge N.
- MULT: unsigned shift-add on magnitudes, one multiplier bit per cycle, edges N+1..N+WIDTH, with a 2*WIDTH-bit accumulator.
- DIV: unsigned restoring division on magnitudes, one quotient bit per cycle, edges N+1..N+WIDTH.
- Iteration counter is log2(WIDTH)+1 bits wide and is cleared on accept.
- FINISH, at edge N+WIDTH+1:
  - Apply sign correction and write hi_out/lo_out.
  - done=1 and busy=0 for the cycle following this edge. The state returns to IDLE at the same edge, so a new start may be accepted at edge N+WIDTH+2.
  - Total latency: start edge to done edge = WIDTH+1 cycles (33 for WIDTH=32).
- Mult sign rule: if sign(a) xor sign(b), negate the 2*WIDTH-bit product.
- Div sign rules:
  - quotient is negated if sign(a) xor sign(b), truncating toward zero.
  - remainder takes the sign of the dividend.
  - Invariant: a = q*b + r with |r| < |b|.
- Overflow case: -2^(WIDTH-1) / -1 gives lo_out = 0x80000000 (wraps) and hi_out = 0. No flag is raised.
- Divide by zero:
  - start_div accepted with b==0 skips DIV and goes directly to FINISH at edge N+1.
  - done=1 and div_zero=1 together for one cycle; hi_out/lo_out keep their previous values.
- done and div_zero are registered pulses, cleared at the next edge.
- hi_out/lo_out hold their last result until the next FINISH that writes them, or until reset.
- No outputs change in IDLE except the clearing of the done/div_zero pulses.

Test Plan:
- Reset, then start_mult with a=7, b=0xFFFFFFFD (-3) -> busy=1 for 33 cycles; done pulses at the 33rd edge after start; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy=0 with done.
- start_div a=0xFFFFFFF9 (-7), b=2 -> done after 33 cycles; lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); div_zero=0. Repeat with a=7, b=0xFFFFFFFE -> lo_out=0xFFFFFFFD, hi_out=1.
- start_div a=5, b=0 following a prior mult result -> done and div_zero both pulse at the 2nd edge; hi_out/lo_out unchanged.
- start_mult a=0x80000000, b=0x80000000 -> hi_out=0x40000000, lo_out=0; then start_div a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- start_mult a=3, b=4, then start_div pulsed 10 cycles later while busy -> the div is ignored; result hi_out=0, lo_out=12 at cycle 33; a single done pulse.
- Simultaneous start_mult and start_div with a=6, b=3 -> the mult is executed: lo_out=18, hi_out=0.
- Reset asserted 15 cycles into a div -> the next edge gives busy=0, done=0, hi_out=lo_out=0; no done pulse appears later.
